rv_multicycle_controller: RTL
=============================

# rv_multicycle_controller

Multi-cycle sequencer for the register-file/ALU datapath: fetches 32-bit RISC-V instructions through a ready/request handshake, decodes them, drives the datapath control lines (register selects, immediate, ALU function, source/writeback muxes, link), and owns the program counter. One instruction is in flight at a time. Loads and stores are sequenced through the datapath's memory port with a request/ready handshake. Illegal opcodes halt the core.

## Interface
- NBITS, 8, datapath/PC width
- NREGS, 32, register count; register selects are $clog2(NREGS) bits
- WIDTH_ALUF, 4, ALUControl width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- InstrReq  out  1  fetch request; held until InstrReady
- InstrAddr  out  NBITS  fetch address, equals PC
- Instr  in  32  instruction word, valid when InstrReady=1
- InstrReady  in  1  fetch completes this cycle
- RS1, RS2, RD  out  $clog2(NREGS)  register selects (instr[19:15], [24:20], [11:7], truncated)
- IMM  out  NBITS  sign-extended immediate, low NBITS bits
- ALUControl  out  WIDTH_ALUF  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
- ALUSrc  out  1  1 = SrcB from IMM
- MemtoReg  out  1  1 = writeback from ReadData
- RegWrite  out  1  register-file write strobe, single-cycle pulse
- link, pclink  out  1, NBITS  write PC+4 to RD (JAL/JALR)
- Zero, Neg, Carry  in  1 each  flags from SUB (Carry=1 means SrcA<SrcB unsigned)
- PCReg  in  NBITS  RS1 value, JALR target base
- MemReq  out  1  data-memory request; held until MemReady
- MemWrite  out  1  1 = store, valid with MemReq
- MemReady  in  1  data access completes this cycle
- PC  out  NBITS  current program counter
- Halted  out  1  core stopped on illegal instruction

## Operation
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH: InstrReq=1; on InstrReady latch Instr into IR -> DECODE; else stay.
- DECODE: register selects, IMM, ALUControl, ALUSrc driven from IR; no writes -> EXEC, or HALT if opcode/funct unsupported.
- Supported: R-type ADD SUB AND OR XOR SLT SLTU SLL SRL SRA; ADDI ANDI ORI XORI SLTI; LW; SW; BEQ BNE BLT BGE BLTU BGEU; JAL; JALR.
- EXEC, ALU ops: RegWrite=1 one cycle, PC<=PC+4 -> FETCH.
- EXEC, branch: ALUControl=SUB, ALUSrc=0; taken if BEQ Zero, BNE !Zero, BLT Neg, BGE !Neg, BLTU Carry, BGEU !Carry; PC<=PC+IMM if taken else PC+4 -> FETCH.
- EXEC, JAL: link=1, pclink=PC+4, RegWrite=1, PC<=PC+IMM. JALR: same write, PC<=(PCReg+IMM) with bit0 cleared -> FETCH.
- EXEC, LW/SW: ALUControl=ADD, ALUSrc=1 -> MEM.
- MEM: MemReq=1, MemWrite=1 for SW; on MemReady: LW asserts MemtoReg=1 and RegWrite=1 that cycle; both PC<=PC+4 -> FETCH.
- HALT: terminal until reset; Halted=1, all strobes 0.
- All PC arithmetic modulo 2^NBITS (wrap, no flag). RD=0 writes issued normally; datapath discards them.
- Control lines not used by the current state are 0.

## Timing
- Reset: state FETCH, PC=0, IR=0; outputs InstrReq=0 during reset cycle, then 1; all other outputs 0, Halted=0.
- Reset mid-handshake aborts request the same cycle; in-flight InstrReady/MemReady ignored.
- Latency with zero-wait memories: ALU/branch/jump 3 cycles, LW/SW 4 cycles; each wait cycle adds one.
- RegWrite never asserted outside EXEC/MEM; at most one pulse per instruction.
- InstrReq/MemReq deassert the cycle after the accepting Ready.
- PC updates on the edge leaving EXEC (non-memory) or MEM.

## Test plan
- Reset, Instr=ADDI x1,x0,5 zero-wait -> InstrAddr 0, RegWrite pulse in cycle 3 with ALUSrc=1, IMM=5, RD=1; PC=4 afterwards.
- BEQ offset -8 at PC=0x10, Zero=1 -> PC=0x08; repeat with Zero=0 -> PC=0x14.
- LW with MemReady delayed 3 cycles -> MemReq held 4 cycles, MemtoReg=RegWrite=1 only in accept cycle, 7 cycles total.
- JAL x1,+12 at PC=0xF8 -> pclink=0xFC, link=1, PC wraps to 0x04.
- Opcode 0x7F -> Halted=1 after DECODE, no further InstrReq until reset.
- Reset asserted while InstrReq waiting -> InstrReq=0 that cycle, PC=0, fetch restarts at 0.

Source files
------------

// File: rtl/rv_multicycle_controller.sv
// rv_multicycle_controller
//   Multi-cycle control sequencer for a RISC-V register-file/ALU datapath.
//   One instruction is in flight at a time: FETCH -> DECODE -> EXEC [-> MEM].
//   Illegal or unsupported instructions park the core in HALT until reset.
//
// Ports
//   clock, reset              : single clock, synchronous active-high reset
//   InstrReq/InstrAddr        : fetch request and address (address = PC)
//   Instr/InstrReady          : instruction word, accepted when InstrReady=1
//   RS1/RS2/RD                : register selects taken from the instruction
//   IMM                       : sign-extended immediate, low NBITS bits
//   ALUControl/ALUSrc         : ALU function and SrcB select (1 = IMM)
//   MemtoReg/RegWrite         : writeback select and single-cycle write strobe
//   link/pclink               : write PC+4 to RD for JAL/JALR
//   Zero/Neg/Carry            : SUB flags used to resolve branches
//   PCReg                     : RS1 value, base of the JALR target
//   MemReq/MemWrite/MemReady  : data-memory handshake (MemWrite=1 for SW)
//   PC/Halted                 : program counter and halt indication
module rv_multicycle_controller #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     InstrReq,
    output logic [NBITS-1:0]         InstrAddr,
    input  logic [31:0]              Instr,
    input  logic                     InstrReady,
    output logic [$clog2(NREGS)-1:0] RS1,
    output logic [$clog2(NREGS)-1:0] RS2,
    output logic [$clog2(NREGS)-1:0] RD,
    output logic [NBITS-1:0]         IMM,
    output logic [WIDTH_ALUF-1:0]    ALUControl,
    output logic                     ALUSrc,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     link,
    output logic [NBITS-1:0]         pclink,
    input  logic                     Zero,
    input  logic                     Neg,
    input  logic                     Carry,
    input  logic [NBITS-1:0]         PCReg,
    output logic                     MemReq,
    output logic                     MemWrite,
    input  logic                     MemReady,
    output logic [NBITS-1:0]         PC,
    output logic                     Halted
);

    localparam int RW = $clog2(NREGS);

    localparam logic [WIDTH_ALUF-1:0] ALU_ADD  = WIDTH_ALUF'(0);
    localparam logic [WIDTH_ALUF-1:0] ALU_SUB  = WIDTH_ALUF'(1);
    localparam logic [WIDTH_ALUF-1:0] ALU_AND  = WIDTH_ALUF'(2);
    localparam logic [WIDTH_ALUF-1:0] ALU_OR   = WIDTH_ALUF'(3);
    localparam logic [WIDTH_ALUF-1:0] ALU_XOR  = WIDTH_ALUF'(4);
    localparam logic [WIDTH_ALUF-1:0] ALU_SLT  = WIDTH_ALUF'(5);
    localparam logic [WIDTH_ALUF-1:0] ALU_SLTU = WIDTH_ALUF'(6);
    localparam logic [WIDTH_ALUF-1:0] ALU_SLL  = WIDTH_ALUF'(7);
    localparam logic [WIDTH_ALUF-1:0] ALU_SRL  = WIDTH_ALUF'(8);
    localparam logic [WIDTH_ALUF-1:0] ALU_SRA  = WIDTH_ALUF'(9);

    localparam logic [NBITS-1:0] FOUR = NBITS'(4);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;
    typedef enum logic [2:0] {C_ALU, C_BR, C_JAL, C_JALR, C_LW, C_SW, C_ILL} cls_t;

    state_t                  state, state_next;
    logic [31:0]             ir;
    logic [NBITS-1:0]        pc, pc_next;

    cls_t                    cls;
    logic [WIDTH_ALUF-1:0]   dec_aluf;
    logic                    dec_alusrc;
    logic [NBITS-1:0]        dec_imm;
    logic                    taken;
    logic                    fields_on;

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [NBITS-1:0]        imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Immediates are sign-extended (or truncated) straight to NBITS.
    assign imm_i = NBITS'(signed'(ir[31:20]));
    assign imm_s = NBITS'(signed'({ir[31:25], ir[11:7]}));
    assign imm_b = NBITS'(signed'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_j = NBITS'(signed'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

    assign InstrAddr = pc;
    assign PC        = pc;

    // Instruction classification from the latched IR.
    always_comb begin
        cls        = C_ILL;
        dec_aluf   = ALU_ADD;
        dec_alusrc = 1'b0;
        dec_imm    = '0;
        case (opcode)
            7'b0110011: begin
                cls = C_ALU;
                case ({funct7, funct3})
                    10'h000: dec_aluf = ALU_ADD;
                    10'h100: dec_aluf = ALU_SUB;
                    10'h007: dec_aluf = ALU_AND;
                    10'h006: dec_aluf = ALU_OR;
                    10'h004: dec_aluf = ALU_XOR;
                    10'h002: dec_aluf = ALU_SLT;
                    10'h003: dec_aluf = ALU_SLTU;
                    10'h001: dec_aluf = ALU_SLL;
                    10'h005: dec_aluf = ALU_SRL;
                    10'h105: dec_aluf = ALU_SRA;
                    default: cls = C_ILL;
                endcase
            end
            7'b0010011: begin
                cls        = C_ALU;
                dec_alusrc = 1'b1;
                dec_imm    = imm_i;
                case (funct3)
                    3'b000:  dec_aluf = ALU_ADD;
                    3'b111:  dec_aluf = ALU_AND;
                    3'b110:  dec_aluf = ALU_OR;
                    3'b100:  dec_aluf = ALU_XOR;
                    3'b010:  dec_aluf = ALU_SLT;
                    default: cls = C_ILL;
                endcase
            end
            7'b0000011: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_i;
                if (funct3 == 3'b010) cls = C_LW;
            end
            7'b0100011: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_s;
                if (funct3 == 3'b010) cls = C_SW;
            end
            7'b1100011: begin
                dec_aluf = ALU_SUB;
                dec_imm  = imm_b;
                if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BR;
            end
            7'b1101111: begin
                dec_imm = imm_j;
                cls     = C_JAL;
            end
            7'b1100111: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_i;
                if (funct3 == 3'b000) cls = C_JALR;
            end
            default: cls = C_ILL;
        endcase
    end

    // Branch condition from the SUB flags.
    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Neg;
            3'b101:  taken = !Neg;
            3'b110:  taken = Carry;
            3'b111:  taken = !Carry;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH && InstrReady) ir <= Instr;
        end
    end

    // Decoded fields are only presented while an instruction is being worked on.
    assign fields_on = !reset && (state == DECODE || state == EXEC || state == MEM);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        InstrReq   = 1'b0;
        RS1        = '0;
        RS2        = '0;
        RD         = '0;
        IMM        = '0;
        ALUControl = '0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        link       = 1'b0;
        pclink     = '0;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        Halted     = 1'b0;

        if (fields_on) begin
            RS1        = ir[15 +: RW];
            RS2        = ir[20 +: RW];
            RD         = ir[7 +: RW];
            IMM        = dec_imm;
            ALUControl = dec_aluf;
            ALUSrc     = dec_alusrc;
        end

        // Reset masks every output combinationally so a pending handshake
        // is dropped in the same cycle reset is seen.
        if (!reset) begin
            case (state)
                FETCH: begin
                    InstrReq = 1'b1;
                    if (InstrReady) state_next = DECODE;
                end
                DECODE: begin
                    state_next = (cls == C_ILL) ? HALT : EXEC;
                end
                EXEC: begin
                    state_next = FETCH;
                    case (cls)
                        C_ALU: begin
                            RegWrite = 1'b1;
                            pc_next  = pc + FOUR;
                        end
                        C_BR: begin
                            pc_next = taken ? pc + dec_imm : pc + FOUR;
                        end
                        C_JAL: begin
                            link     = 1'b1;
                            pclink   = pc + FOUR;
                            RegWrite = 1'b1;
                            pc_next  = pc + dec_imm;
                        end
                        C_JALR: begin
                            link     = 1'b1;
                            pclink   = pc + FOUR;
                            RegWrite = 1'b1;
                            pc_next  = {(PCReg + dec_imm) >> 1, 1'b0};
                        end
                        C_LW, C_SW: state_next = MEM;
                        default:    state_next = HALT;
                    endcase
                end
                MEM: begin
                    MemReq   = 1'b1;
                    MemWrite = (cls == C_SW);
                    if (MemReady) begin
                        MemtoReg   = (cls == C_LW);
                        RegWrite   = (cls == C_LW);
                        pc_next    = pc + FOUR;
                        state_next = FETCH;
                    end
                end
                HALT: begin
                    Halted = 1'b1;
                end
                default: state_next = HALT;
            endcase
        end
    end

endmodule
